// File: rtl/sig_meas_pkg.sv
// ---------------------------------------------------------------------------
// sig_meas_pkg
// Shared types and helpers for the sig_meas ADC measurement block.
//   state_t  : measurement FSM states
//   DEF_*    : default sample / counter widths and hysteresis
//   sat_add  : unsigned add clamped to an upper limit
//   sat_sub  : unsigned subtract clamped at zero
// ---------------------------------------------------------------------------
package sig_meas_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_PEAK,
    ST_EDGE,
    ST_PERIOD,
    ST_DONE
  } state_t;

  localparam int DEF_DW    = 8;
  localparam int DEF_CNT_W = 24;
  localparam int DEF_HYST  = 8;

  function automatic logic [31:0] sat_add(input logic [31:0] a,
                                          input logic [31:0] b,
                                          input logic [31:0] lim);
    logic [32:0] sum;
    sum = {1'b0, a} + {1'b0, b};
    return (sum > {1'b0, lim}) ? lim : sum[31:0];
  endfunction

  function automatic logic [31:0] sat_sub(input logic [31:0] a,
                                          input logic [31:0] b);
    return (a > b) ? (a - b) : 32'd0;
  endfunction

endpackage

// File: rtl/sig_edge_det.sv
// ---------------------------------------------------------------------------
// sig_edge_det
// Schmitt comparator on the ADC sample stream with a registered state s.
//   clk, rst   : clock, asynchronous active-high reset
//   sample_i   : unsigned sample
//   valid_i    : sample strobe (already gated by the caller's phase)
//   init_i     : arm; the next valid sample seeds s = (sample >= mid)
//   thr_hi_i   : rising threshold (0 -> 1 when sample >= thr_hi)
//   thr_lo_i   : falling threshold (1 -> 0 when sample <= thr_lo)
//   mid_i      : midpoint used only for seeding
//   rise_o     : high during the cycle of a valid sample causing 0 -> 1
//   s_nxt_o    : value s takes after the current sample
// ---------------------------------------------------------------------------
module sig_edge_det
  import sig_meas_pkg::*;
#(
  parameter int DW = DEF_DW
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [DW-1:0] sample_i,
  input  logic          valid_i,
  input  logic          init_i,
  input  logic [DW-1:0] thr_hi_i,
  input  logic [DW-1:0] thr_lo_i,
  input  logic [DW-1:0] mid_i,
  output logic          rise_o,
  output logic          s_nxt_o
);

  logic s_q, s_d;
  logic need_init_q, need_init_d;

  always_comb begin
    s_d         = s_q;
    need_init_d = need_init_q;
    rise_o      = 1'b0;
    if (init_i) begin
      need_init_d = 1'b1;
      s_d         = 1'b0;
    end else if (valid_i) begin
      if (need_init_q) begin
        // Seeding sample never counts as a crossing.
        s_d         = (sample_i >= mid_i);
        need_init_d = 1'b0;
      end else if (!s_q && (sample_i >= thr_hi_i)) begin
        s_d    = 1'b1;
        rise_o = 1'b1;
      end else if (s_q && (sample_i <= thr_lo_i)) begin
        s_d = 1'b0;
      end
    end
    s_nxt_o = s_d;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s_q         <= 1'b0;
      need_init_q <= 1'b0;
    end else begin
      s_q         <= s_d;
      need_init_q <= need_init_d;
    end
  end

endmodule

// File: rtl/sig_meas.sv
// ---------------------------------------------------------------------------
// sig_meas
// ADC-side measurement: min/max/peak-to-peak over a WIN-sample window, then
// one full period and its high time via a hysteresis midpoint crossing.
//   clk, rst          : clock, asynchronous active-high reset
//   ad_data, ad_valid : unsigned ADC sample and its strobe
//   start             : single-cycle request, accepted only in IDLE
//   ad_clk            : ADC sample clock (= clk)
//   busy              : measurement in progress (PEAK/EDGE/PERIOD)
//   done              : one-cycle pulse while new results are presented
//   vmax, vmin, vpp   : amplitude results
//   period, high_cnt  : samples per period / samples high in that period
//   no_sig            : amplitude too small, no edge search was done
//   timeout           : no full period found within TMO samples
// ---------------------------------------------------------------------------
module sig_meas
  import sig_meas_pkg::*;
#(
  parameter int DW    = DEF_DW,
  parameter int CNT_W = DEF_CNT_W,
  parameter int WIN   = 4096,
  parameter int TMO   = 1000000,
  parameter int HYST  = DEF_HYST
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [DW-1:0]    ad_data,
  input  logic             ad_valid,
  input  logic             start,
  output logic             ad_clk,
  output logic             busy,
  output logic             done,
  output logic [DW-1:0]    vmax,
  output logic [DW-1:0]    vmin,
  output logic [DW-1:0]    vpp,
  output logic [CNT_W-1:0] period,
  output logic [CNT_W-1:0] high_cnt,
  output logic             no_sig,
  output logic             timeout
);

  localparam int WIN_W = $clog2(WIN + 1);

  state_t state_q, state_d;

  logic [DW-1:0]    run_max_q, run_max_d, run_min_q, run_min_d;
  logic [WIN_W-1:0] win_cnt_q, win_cnt_d;
  logic [DW-1:0]    mid_q, mid_d, thr_hi_q, thr_hi_d, thr_lo_q, thr_lo_d;
  logic [CNT_W-1:0] per_cnt_q, per_cnt_d, hi_cnt_q, hi_cnt_d;
  logic [CNT_W-1:0] tmo_cnt_q, tmo_cnt_d;
  logic [DW-1:0]    vmax_q, vmax_d, vmin_q, vmin_d, vpp_q, vpp_d;
  logic [CNT_W-1:0] period_q, period_d, high_q, high_d;
  logic             no_sig_q, no_sig_d, timeout_q, timeout_d;

  logic             win_full, small_amp, tmo_last, edge_init, edge_valid;
  logic             rise, s_nxt, load_res;
  logic [DW-1:0]    amp;
  logic [DW:0]      mid_w;
  logic [DW-1:0]    thr_hi_w, thr_lo_w;

  assign ad_clk = clk;

  assign amp       = run_max_q - run_min_q;
  assign win_full  = (win_cnt_q == WIN_W'(WIN));
  assign small_amp = ({1'b0, amp} <= (DW + 1)'(2 * HYST));
  // Sum in DW+1 bits so max+min cannot wrap before halving.
  assign mid_w     = ({1'b0, run_max_q} + {1'b0, run_min_q}) >> 1;
  assign thr_hi_w  = DW'(sat_add(32'(mid_w), 32'(HYST), 32'((1 << DW) - 1)));
  assign thr_lo_w  = DW'(sat_sub(32'(mid_w), 32'(HYST)));
  // The valid sample arriving with tmo_cnt == TMO-1 is the TMO-th one.
  assign tmo_last  = (tmo_cnt_q == CNT_W'(TMO - 1));

  assign edge_init  = (state_q == ST_PEAK) && win_full && !small_amp;
  assign edge_valid = ad_valid && ((state_q == ST_EDGE) || (state_q == ST_PERIOD));

  sig_edge_det #(
    .DW (DW)
  ) u_edge (
    .clk      (clk),
    .rst      (rst),
    .sample_i (ad_data),
    .valid_i  (edge_valid),
    .init_i   (edge_init),
    .thr_hi_i (thr_hi_q),
    .thr_lo_i (thr_lo_q),
    .mid_i    (mid_q),
    .rise_o   (rise),
    .s_nxt_o  (s_nxt)
  );

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:   if (start) state_d = ST_PEAK;
      ST_PEAK:   if (win_full) state_d = small_amp ? ST_DONE : ST_EDGE;
      ST_EDGE: begin
        if (rise)                     state_d = ST_PERIOD;
        else if (ad_valid && tmo_last) state_d = ST_DONE;
      end
      ST_PERIOD: begin
        if (rise)                     state_d = ST_DONE;
        else if (ad_valid && tmo_last) state_d = ST_DONE;
      end
      ST_DONE:   state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  // FSM outputs
  always_comb begin
    busy = 1'b0;
    done = 1'b0;
    case (state_q)
      ST_PEAK, ST_EDGE, ST_PERIOD: busy = 1'b1;
      ST_DONE:                     done = 1'b1;
      default: ;
    endcase
  end

  // Datapath next values; results are loaded on the edge entering DONE so
  // they are already stable while done is high.
  always_comb begin
    run_max_d = run_max_q;
    run_min_d = run_min_q;
    win_cnt_d = win_cnt_q;
    mid_d     = mid_q;
    thr_hi_d  = thr_hi_q;
    thr_lo_d  = thr_lo_q;
    per_cnt_d = per_cnt_q;
    hi_cnt_d  = hi_cnt_q;
    tmo_cnt_d = tmo_cnt_q;
    vmax_d    = vmax_q;
    vmin_d    = vmin_q;
    vpp_d     = vpp_q;
    period_d  = period_q;
    high_d    = high_q;
    no_sig_d  = no_sig_q;
    timeout_d = timeout_q;
    load_res  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          run_max_d = '0;
          run_min_d = '1;
          win_cnt_d = '0;
        end
      end
      ST_PEAK: begin
        if (win_full) begin
          // Threshold cycle: the sample present now is not used.
          mid_d     = mid_w[DW-1:0];
          thr_hi_d  = thr_hi_w;
          thr_lo_d  = thr_lo_w;
          tmo_cnt_d = '0;
          if (small_amp) begin
            load_res  = 1'b1;
            period_d  = '0;
            high_d    = '0;
            no_sig_d  = 1'b1;
            timeout_d = 1'b0;
          end
        end else if (ad_valid) begin
          if (ad_data > run_max_q) run_max_d = ad_data;
          if (ad_data < run_min_q) run_min_d = ad_data;
          win_cnt_d = win_cnt_q + 1'b1;
        end
      end
      ST_EDGE: begin
        if (ad_valid) begin
          tmo_cnt_d = tmo_cnt_q + 1'b1;
          if (rise) begin
            per_cnt_d = CNT_W'(1);
            hi_cnt_d  = CNT_W'(1);
          end else if (tmo_last) begin
            load_res  = 1'b1;
            period_d  = '0;
            high_d    = '0;
            no_sig_d  = 1'b0;
            timeout_d = 1'b1;
          end
        end
      end
      ST_PERIOD: begin
        if (ad_valid) begin
          tmo_cnt_d = tmo_cnt_q + 1'b1;
          if (rise) begin
            // Closing crossing belongs to the next period.
            load_res  = 1'b1;
            period_d  = per_cnt_q;
            high_d    = hi_cnt_q;
            no_sig_d  = 1'b0;
            timeout_d = 1'b0;
          end else begin
            per_cnt_d = per_cnt_q + 1'b1;
            hi_cnt_d  = hi_cnt_q + CNT_W'(s_nxt);
            if (tmo_last) begin
              load_res  = 1'b1;
              period_d  = '0;
              high_d    = '0;
              no_sig_d  = 1'b0;
              timeout_d = 1'b1;
            end
          end
        end
      end
      default: ;
    endcase
    if (load_res) begin
      vmax_d = run_max_q;
      vmin_d = run_min_q;
      vpp_d  = amp;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      run_max_q <= '0;
      run_min_q <= '0;
      win_cnt_q <= '0;
      mid_q     <= '0;
      thr_hi_q  <= '0;
      thr_lo_q  <= '0;
      per_cnt_q <= '0;
      hi_cnt_q  <= '0;
      tmo_cnt_q <= '0;
      vmax_q    <= '0;
      vmin_q    <= '0;
      vpp_q     <= '0;
      period_q  <= '0;
      high_q    <= '0;
      no_sig_q  <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      run_max_q <= run_max_d;
      run_min_q <= run_min_d;
      win_cnt_q <= win_cnt_d;
      mid_q     <= mid_d;
      thr_hi_q  <= thr_hi_d;
      thr_lo_q  <= thr_lo_d;
      per_cnt_q <= per_cnt_d;
      hi_cnt_q  <= hi_cnt_d;
      tmo_cnt_q <= tmo_cnt_d;
      vmax_q    <= vmax_d;
      vmin_q    <= vmin_d;
      vpp_q     <= vpp_d;
      period_q  <= period_d;
      high_q    <= high_d;
      no_sig_q  <= no_sig_d;
      timeout_q <= timeout_d;
    end
  end

  assign vmax     = vmax_q;
  assign vmin     = vmin_q;
  assign vpp      = vpp_q;
  assign period   = period_q;
  assign high_cnt = high_q;
  assign no_sig   = no_sig_q;
  assign timeout  = timeout_q;

endmodule

// File: tb/tb_sig_meas.sv
// ---------------------------------------------------------------------------
// tb_sig_meas
// Directed bench for sig_meas with a shortened window (WIN=512) and timeout
// (TMO=1000). Waveforms are generated from a sample index that advances only
// on valid samples; expected values are worked out by hand from the waveform.
// ---------------------------------------------------------------------------
module tb_sig_meas;

  localparam int DW    = 8;
  localparam int CNT_W = 24;
  localparam int WIN   = 512;
  localparam int TMO   = 1000;
  localparam int HYST  = 8;

  logic             clk = 1'b0;
  logic             rst;
  logic [DW-1:0]    ad_data;
  logic             ad_valid;
  logic             start;
  logic             ad_clk;
  logic             busy;
  logic             done;
  logic [DW-1:0]    vmax, vmin, vpp;
  logic [CNT_W-1:0] period, high_cnt;
  logic             no_sig, timeout;

  int checks = 0;
  int errors = 0;

  // 0 square 30/70, 1 sine 256 pts, 2 constant 128, 3 ramp then hold 255
  int mode;
  bit gate;
  bit tog;
  int ph;
  int sine_tab[256];

  always #5 clk = ~clk;

  sig_meas #(
    .DW    (DW),
    .CNT_W (CNT_W),
    .WIN   (WIN),
    .TMO   (TMO),
    .HYST  (HYST)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .ad_data  (ad_data),
    .ad_valid (ad_valid),
    .start    (start),
    .ad_clk   (ad_clk),
    .busy     (busy),
    .done     (done),
    .vmax     (vmax),
    .vmin     (vmin),
    .vpp      (vpp),
    .period   (period),
    .high_cnt (high_cnt),
    .no_sig   (no_sig),
    .timeout  (timeout)
  );

  function automatic int sample_of(input int n);
    case (mode)
      0:       return ((n % 100) < 30) ? 255 : 0;
      1:       return sine_tab[n % 256];
      2:       return 128;
      default: return (n < 256) ? n : 255;
    endcase
  endfunction

  task automatic drive_next();
    if (gate) begin
      ad_valid = tog;
      tog      = ~tog;
    end else begin
      ad_valid = 1'b1;
    end
    if (ad_valid) begin
      ad_data = DW'(sample_of(ph));
      ph++;
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic chk_rng(input string tag, input logic [31:0] obs,
                         input int lo, input int hi);
    checks++;
    assert ((obs >= 32'(lo)) && (obs <= 32'(hi)))
    else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d..%0d", tag, obs, lo, hi);
    end
  endtask

  // Issue start, then stream samples until done. lat counts clock edges
  // after the edge that sampled start. restart_at >= 0 re-pulses start then.
  task automatic measure(input int restart_at, output int lat, output bit got);
    @(negedge clk);
    start    = 1'b1;
    ad_valid = 1'b0;
    ph       = 0;
    tog      = 1'b0;
    @(negedge clk);
    start = 1'b0;
    lat   = 0;
    got   = 1'b0;
    while (lat < 5000) begin
      if (done) begin
        got = 1'b1;
        break;
      end
      start = (lat == restart_at);
      drive_next();
      @(negedge clk);
      lat++;
    end
    start = 1'b0;
    checks++;
    assert (got)
    else begin
      errors++;
      $error("FAIL done_wait observed=no_done expected=done within 5000 cycles");
    end
  endtask

  task automatic idle(input int n, output int dones);
    dones = 0;
    for (int i = 0; i < n; i++) begin
      drive_next();
      @(negedge clk);
      if (done) dones++;
    end
  endtask

  initial begin
    int lat;
    bit got;
    int dones;

    for (int k = 0; k < 256; k++)
      sine_tab[k] = int'(127.0 + 127.0 * $sin(2.0 * 3.14159265358979 * k / 256.0));

    rst      = 1'b1;
    start    = 1'b0;
    ad_valid = 1'b0;
    ad_data  = '0;
    mode     = 0;
    gate     = 1'b0;
    tog      = 1'b0;
    ph       = 0;

    // Reset state
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_vmax", 32'(vmax), 0);
    chk("rst_period", 32'(period), 0);
    chk("rst_flags", {30'd0, no_sig, timeout}, 0);
    chk("ad_clk_low", 32'(ad_clk), 32'(clk));

    // Square 0/255, 30 high + 70 low
    mode = 0; gate = 1'b0;
    measure(-1, lat, got);
    chk("sq_vmax", 32'(vmax), 255);
    chk("sq_vmin", 32'(vmin), 0);
    chk("sq_vpp", 32'(vpp), 255);
    chk("sq_period", 32'(period), 100);
    chk("sq_high", 32'(high_cnt), 30);
    chk("sq_flags", {30'd0, no_sig, timeout}, 0);
    chk("sq_busy_in_done", 32'(busy), 0);
    // start presented during the DONE cycle must be ignored
    start = 1'b1;
    drive_next();
    @(negedge clk);
    start = 1'b0;
    chk("sq_done_pulse", 32'(done), 0);
    chk("sq_start_in_done", 32'(busy), 0);

    // Sine 0..254, 256 points
    mode = 1;
    measure(-1, lat, got);
    chk_rng("sin_vpp", 32'(vpp), 253, 255);
    chk("sin_period", 32'(period), 256);
    chk_rng("sin_high", 32'(high_cnt), 126, 130);
    chk("sin_nosig", 32'(no_sig), 0);

    // Constant 128: no signal right after the window
    mode = 2;
    measure(-1, lat, got);
    chk("const_lat", 32'(lat), WIN + 1);
    chk("const_nosig", 32'(no_sig), 1);
    chk("const_vpp", 32'(vpp), 0);
    chk("const_vmax", 32'(vmax), 128);
    chk("const_period", 32'(period), 0);
    chk("const_high", 32'(high_cnt), 0);

    // Ramp then hold at 255: no crossing, timeout after TMO samples
    mode = 3;
    measure(-1, lat, got);
    chk("ramp_lat", 32'(lat), WIN + 1 + TMO);
    chk("ramp_timeout", 32'(timeout), 1);
    chk("ramp_nosig", 32'(no_sig), 0);
    chk("ramp_period", 32'(period), 0);
    chk("ramp_vmin", 32'(vmin), 0);

    // Valid-gated square with an extra start while busy
    mode = 0; gate = 1'b1;
    measure(300, lat, got);
    chk("gate_period", 32'(period), 100);
    chk("gate_high", 32'(high_cnt), 30);
    chk("gate_timeout", 32'(timeout), 0);
    idle(200, dones);
    chk("gate_extra_done", 32'(dones), 0);
    chk("gate_busy_after", 32'(busy), 0);

    // Reset in the middle of PERIOD
    mode = 0; gate = 1'b0;
    @(negedge clk);
    start    = 1'b1;
    ad_valid = 1'b0;
    ph       = 0;
    @(negedge clk);
    start = 1'b0;
    repeat (650) begin
      drive_next();
      @(negedge clk);
    end
    chk("mid_busy", 32'(busy), 1);
    #2 rst = 1'b1;
    #1;
    chk("arst_busy", 32'(busy), 0);
    chk("arst_vmax", 32'(vmax), 0);
    chk("arst_vpp", 32'(vpp), 0);
    chk("arst_period", 32'(period), 0);
    chk("arst_high", 32'(high_cnt), 0);
    @(negedge clk);
    rst = 1'b0;
    measure(-1, lat, got);
    chk("post_period", 32'(period), 100);
    chk("post_high", 32'(high_cnt), 30);
    chk("post_vpp", 32'(vpp), 255);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
